// File: rtl/red_pitaya_haze_mixer.sv
// N-channel weighted-sum mixer: dat_o = sat(sum(dat_k * gain_k) >>> GAINSR), 3-stage pipeline.
// Optional programmable min/max limit stage, compiled in with `define HAZE_MIXER_LIMIT_EN.

module red_pitaya_haze_mixer #(
  parameter int NCH      = 4,
  parameter int GAINBITS = 24,
  parameter int GAINSR   = 12
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NCH*14-1:0] dat_i,
  output logic [13:0]       dat_o,
  output logic              sat_o,
  input  logic [15:0]       addr,
  input  logic              wen,
  input  logic              ren,
  output logic              ack,
  output logic [31:0]       rdata,
  input  logic [31:0]       wdata
);

  localparam int PW = 14 + GAINBITS;
  localparam int SW = PW + $clog2(NCH);

  localparam logic [15:0] GAIN_BASE   = 16'h0100;
  localparam logic [15:0] ADDR_APPLY  = 16'h0140;
  localparam logic [15:0] ADDR_CTRL   = 16'h0144;
  localparam logic [15:0] ADDR_SATCNT = 16'h0148;
  localparam logic [15:0] ADDR_NCH    = 16'h0200;
  localparam logic [15:0] ADDR_SR     = 16'h0204;
  localparam logic [15:0] ADDR_GBITS  = 16'h020C;

  localparam logic signed [SW-1:0] Y_MAX = SW'(8191);
  localparam logic signed [SW-1:0] Y_MIN = SW'(-8192);

  logic signed [GAINBITS-1:0] shadow_gain [NCH];
  logic signed [GAINBITS-1:0] active_gain [NCH];
  logic signed [13:0]         dat_ch      [NCH];
  logic signed [PW-1:0]       prod        [NCH];
  logic signed [SW-1:0]       sum_c;
  logic signed [SW-1:0]       y_q;
  logic signed [13:0]         dat_c;
  logic                       sat_c;
  logic                       enable;
  logic [15:0]                sat_cnt;
  logic [31:0]                rd_c;
  logic                       apply_wr;
  logic                       ctrl_wr;
  logic                       clr_wr;
  logic                       unused_wdata;

  assign apply_wr     = wen && (addr == ADDR_APPLY);
  assign ctrl_wr      = wen && (addr == ADDR_CTRL);
  assign clr_wr       = ctrl_wr && wdata[1];
  assign unused_wdata = ^wdata;

  // Shadow gains take bus writes; active gains only change on APPLY, all at once.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < NCH; k++) begin
        shadow_gain[k] <= '0;
        active_gain[k] <= '0;
      end
      enable <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (wen && (addr == GAIN_BASE + 16'(4 * k)))
          shadow_gain[k] <= wdata[GAINBITS-1:0];
      end
      if (apply_wr) begin
        for (int k = 0; k < NCH; k++)
          active_gain[k] <= shadow_gain[k];
      end
      if (ctrl_wr)
        enable <= wdata[0];
    end
  end

`ifdef HAZE_MIXER_LIMIT_EN
  localparam logic [15:0] ADDR_MIN = 16'h014C;
  localparam logic [15:0] ADDR_MAX = 16'h0150;

  logic signed [13:0] lim_min;
  logic signed [13:0] lim_max;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      lim_min <= 14'sh2000;
      lim_max <= 14'sh1FFF;
    end else begin
      if (wen && (addr == ADDR_MIN))
        lim_min <= wdata[13:0];
      if (wen && (addr == ADDR_MAX))
        lim_max <= wdata[13:0];
    end
  end
`endif

  always_comb begin
    for (int k = 0; k < NCH; k++)
      dat_ch[k] = dat_i[14*k +: 14];
  end

  // S1: full-precision products, so no rounding happens before the sum.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < NCH; k++)
        prod[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++)
        prod[k] <= PW'(dat_ch[k]) * PW'(active_gain[k]);
    end
  end

  // S2: sum is wide enough for NCH worst-case products; shift floors toward -inf.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NCH; k++)
      sum_c = sum_c + SW'(prod[k]);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i)
      y_q <= '0;
    else
      y_q <= sum_c >>> GAINSR;
  end

  // S3: fixed 14-bit saturation, then optional limit stage; disable forces zero.
  always_comb begin
    sat_c = 1'b0;
    if (y_q > Y_MAX) begin
      dat_c = 14'sh1FFF;
      sat_c = 1'b1;
    end else if (y_q < Y_MIN) begin
      dat_c = 14'sh2000;
      sat_c = 1'b1;
    end else begin
      dat_c = y_q[13:0];
    end
`ifdef HAZE_MIXER_LIMIT_EN
    if (dat_c > lim_max) begin
      dat_c = lim_max;
      sat_c = 1'b1;
    end else if (dat_c < lim_min) begin
      dat_c = lim_min;
      sat_c = 1'b1;
    end
`endif
    if (!enable) begin
      dat_c = '0;
      sat_c = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      dat_o <= '0;
      sat_o <= 1'b0;
    end else begin
      dat_o <= dat_c;
      sat_o <= sat_c;
    end
  end

  // Clear beats a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rstn_i)
      sat_cnt <= '0;
    else if (clr_wr)
      sat_cnt <= '0;
    else if (sat_c && (sat_cnt != 16'hFFFF))
      sat_cnt <= sat_cnt + 16'd1;
  end

  always_comb begin
    rd_c = '0;
    case (addr)
      ADDR_CTRL:   rd_c = {31'd0, enable};
      ADDR_SATCNT: rd_c = {16'd0, sat_cnt};
`ifdef HAZE_MIXER_LIMIT_EN
      ADDR_MIN:    rd_c = 32'(lim_min);
      ADDR_MAX:    rd_c = 32'(lim_max);
`endif
      ADDR_NCH:    rd_c = 32'(NCH);
      ADDR_SR:     rd_c = 32'(GAINSR);
      ADDR_GBITS:  rd_c = 32'(GAINBITS);
      default:     rd_c = '0;
    endcase
    for (int k = 0; k < NCH; k++) begin
      if (addr == GAIN_BASE + 16'(4 * k))
        rd_c = 32'(shadow_gain[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= wen | ren;
      rdata <= ren ? rd_c : 32'd0;
    end
  end

endmodule

// File: tb/tb_red_pitaya_haze_mixer.sv
// Self-checking bench for red_pitaya_haze_mixer: directed scenarios plus randomized traffic
// against an arithmetic reference model. Honours HAZE_MIXER_LIMIT_EN like the design.

module tb_red_pitaya_haze_mixer;

  localparam int NCH      = 4;
  localparam int GAINBITS = 24;
  localparam int GAINSR   = 12;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NCH*14-1:0] dat_i = '0;
  logic [13:0]       dat_o;
  logic              sat_o;
  logic [15:0]       addr = '0;
  logic              wen = 1'b0;
  logic              ren = 1'b0;
  logic              ack;
  logic [31:0]       rdata;
  logic [31:0]       wdata = '0;

  red_pitaya_haze_mixer #(
    .NCH(NCH), .GAINBITS(GAINBITS), .GAINSR(GAINSR)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .dat_i(dat_i), .dat_o(dat_o), .sat_o(sat_o),
    .addr(addr), .wen(wen), .ren(ren), .ack(ack), .rdata(rdata), .wdata(wdata)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  // Reference state: register contents plus the two y values in flight.
  longint            m_shadow [NCH];
  longint            m_active [NCH];
  longint            m_min, m_max, m_y1, m_y2, m_cnt;
  logic              m_en;
  longint            e_dat;
  logic              e_sat, e_ack, e_rvalid;
  logic [31:0]       e_rdata;
  logic [NCH*14-1:0] cur_din = '0;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sext(input longint v, input int bits);
    longint m = longint'(1) << bits;
    longint r = v & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic longint floor_div(input longint s);
    longint q = longint'(1) << GAINSR;
    if (s >= 0) return s / q;
    return -((-s + q - 1) / q);
  endfunction

  function automatic logic [31:0] read_model(input logic [15:0] a);
    for (int k = 0; k < NCH; k++)
      if (a == 16'(256 + 4 * k)) return 32'(m_shadow[k]);
    case (a)
      16'h0144: return {31'd0, m_en};
      16'h0148: return 32'(m_cnt);
`ifdef HAZE_MIXER_LIMIT_EN
      16'h014C: return 32'(m_min);
      16'h0150: return 32'(m_max);
`endif
      16'h0200: return 32'(NCH);
      16'h0204: return 32'(GAINSR);
      16'h020C: return 32'(GAINBITS);
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
    end
    m_min = -8192; m_max = 8191; m_y1 = 0; m_y2 = 0; m_cnt = 0; m_en = 1'b0;
    e_dat = 0; e_sat = 1'b0; e_ack = 1'b0; e_rvalid = 1'b1; e_rdata = '0;
  endtask

  task automatic model_write(input logic [15:0] a, input logic [31:0] d);
    for (int k = 0; k < NCH; k++)
      if (a == 16'(256 + 4 * k)) m_shadow[k] = sext(longint'(d), GAINBITS);
    if (a == 16'h0144) m_en = d[0];
`ifdef HAZE_MIXER_LIMIT_EN
    if (a == 16'h014C) m_min = sext(longint'(d), 14);
    if (a == 16'h0150) m_max = sext(longint'(d), 14);
`endif
  endtask

  // One clock cycle: drive inputs, advance the model, then check outputs after the edge.
  task automatic applyStimulus(input logic rst_n, input logic [NCH*14-1:0] din, input logic w,
                               input logic r, input logic [15:0] a, input logic [31:0] d);
    longint      sum, y_new, v;
    logic        s;
    logic [31:0] rd;
    rstn = rst_n; dat_i = din; wen = w; ren = r; addr = a; wdata = d;
    sum = 0;
    for (int k = 0; k < NCH; k++)
      sum += sext(longint'(din[14*k +: 14]), 14) * m_active[k];
    y_new = floor_div(sum);
    v = m_y2; s = 1'b0;
    if (v > 8191) begin v = 8191; s = 1'b1; end
    else if (v < -8192) begin v = -8192; s = 1'b1; end
`ifdef HAZE_MIXER_LIMIT_EN
    if (v > m_max) begin v = m_max; s = 1'b1; end
    else if (v < m_min) begin v = m_min; s = 1'b1; end
`endif
    if (!m_en) begin v = 0; s = 1'b0; end
    rd = read_model(a);
    if (!rst_n) begin
      model_reset();
    end else begin
      e_dat = v; e_sat = s;
      m_y2 = m_y1; m_y1 = y_new;
      if (w && a == 16'h0144 && d[1]) m_cnt = 0;
      else if (s && m_cnt < 65535) m_cnt++;
      if (w && a == 16'h0140) m_active = m_shadow;
      if (w) model_write(a, d);
      e_ack = w | r; e_rvalid = r; e_rdata = rd;
    end
    @(posedge clk);
    #1;
    checkOutput("dat_o", longint'($signed(dat_o)), e_dat);
    checkOutput("sat_o", longint'(sat_o), longint'(e_sat));
    checkOutput("ack", longint'(ack), longint'(e_ack));
    if (e_rvalid) checkOutput("rdata", longint'(rdata), longint'(e_rdata));
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, cur_din, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [31:0] d);
    applyStimulus(1'b1, cur_din, 1'b1, 1'b0, a, d);
  endtask

  task automatic busRead(input logic [15:0] a);
    applyStimulus(1'b1, cur_din, 1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic setDin(input int c0, input int c1, input int c2, input int c3);
    cur_din = {14'(c3), 14'(c2), 14'(c1), 14'(c0)};
  endtask

  logic [15:0] rd_addrs [16] = '{16'h0100, 16'h0104, 16'h0108, 16'h010C, 16'h0110, 16'h0140,
                                 16'h0144, 16'h0148, 16'h014C, 16'h0150, 16'h0200, 16'h0204,
                                 16'h0208, 16'h020C, 16'h0102, 16'h0300};

  initial begin
    model_reset();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 16'h0, 32'h0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 16'h0148, 32'h0);
    for (int i = 0; i < 16; i++) busRead(rd_addrs[i]);
    busRead(16'h0200);
    checkOutput("nch_const", longint'(rdata), 4);
    busRead(16'h0150);
`ifdef HAZE_MIXER_LIMIT_EN
    checkOutput("max_reset", longint'(rdata), 8191);
`else
    checkOutput("max_absent", longint'(rdata), 0);
`endif

    // Unity gain on channel 0.
    setDin(1000, 0, 0, 0);
    busWrite(16'h0100, 32'h1000);
    busWrite(16'h0140, 32'h0);
    busWrite(16'h0144, 32'h1);
    idle(4);
    checkOutput("t1_dat", longint'($signed(dat_o)), 1000);
    checkOutput("t1_sat", longint'(sat_o), 0);

    // Shadow write is invisible until APPLY; new gain lands 4 cycles after APPLY.
    setDin(1000, 2000, 0, 0);
    busWrite(16'h0104, 32'h0800);
    idle(4);
    checkOutput("t3_hold", longint'($signed(dat_o)), 1000);
    busWrite(16'h0140, 32'h0);
    idle(2);
    checkOutput("t3_early", longint'($signed(dat_o)), 1000);
    idle(1);
    checkOutput("t3_apply", longint'($signed(dat_o)), 2000);

    // Half gain floors toward -inf.
    busWrite(16'h0100, 32'h0800);
    busWrite(16'h0104, 32'h0);
    busWrite(16'h0140, 32'h0);
    setDin(-1, 0, 0, 0);
    idle(4);
    checkOutput("t4_neg", longint'($signed(dat_o)), -1);
    setDin(1, 0, 0, 0);
    idle(4);
    checkOutput("t4_pos", longint'($signed(dat_o)), 0);

    // Saturation both ways.
    for (int k = 0; k < NCH; k++) busWrite(16'(256 + 4 * k), 32'h1000);
    busWrite(16'h0140, 32'h0);
    setDin(3000, 3000, 3000, 3000);
    idle(4);
    checkOutput("t2_hi", longint'($signed(dat_o)), 8191);
    checkOutput("t2_hi_sat", longint'(sat_o), 1);
    busRead(16'h0148);
    busRead(16'h0148);
    setDin(-3000, -3000, -3000, -3000);
    idle(4);
    checkOutput("t2_lo", longint'($signed(dat_o)), -8192);
    checkOutput("t2_lo_sat", longint'(sat_o), 1);

    // Clear during saturation wins, then the count sticks at 0xFFFF.
    busWrite(16'h0144, 32'h3);
    busRead(16'h0148);
    checkOutput("t5_clear", longint'(rdata), 0);
    idle(65540);
    busRead(16'h0148);
    checkOutput("t5_sticky", longint'(rdata), 65535);
    applyStimulus(1'b0, cur_din, 1'b0, 1'b0, 16'h0, 32'h0);
    checkOutput("t5_rst_dat", longint'($signed(dat_o)), 0);
    checkOutput("t5_rst_sat", longint'(sat_o), 0);
    busRead(16'h0148);
    checkOutput("t5_rst_cnt", longint'(rdata), 0);
    busRead(16'h0100);
    busRead(16'h0144);
    idle(4);

`ifdef HAZE_MIXER_LIMIT_EN
    busWrite(16'h0100, 32'h1000);
    busWrite(16'h0140, 32'h0);
    busWrite(16'h0144, 32'h1);
    busWrite(16'h014C, 32'hFFFFFF9C);
    busWrite(16'h0150, 32'd200);
    setDin(500, 0, 0, 0);
    idle(4);
    checkOutput("t6_max", longint'($signed(dat_o)), 200);
    checkOutput("t6_sat", longint'(sat_o), 1);
    busWrite(16'h014C, 32'd300);
    idle(4);
    checkOutput("t6_prio", longint'($signed(dat_o)), 200);
`else
    busWrite(16'h0150, 32'd200);
    busRead(16'h0150);
    checkOutput("t6_absent", longint'(rdata), 0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int          op;
      int          g;
      logic [31:0] d;
      for (int k = 0; k < NCH; k++)
        cur_din[14*k +: 14] = ($urandom_range(0, 1) == 1) ? 14'($urandom())
                                                         : 14'(int'($urandom_range(0, 4000)) - 2000);
      op = int'($urandom_range(0, 11));
      if ($urandom_range(0, 299) == 0) begin
        applyStimulus(1'b0, cur_din, 1'b0, 1'b0, 16'h0, 32'h0);
      end else if (op <= 1) begin
        g = int'($urandom_range(0, 12288)) - 6144;
        d = ($urandom_range(0, 3) == 0) ? $urandom() : 32'(g);
        busWrite(16'(256 + 4 * int'($urandom_range(0, NCH - 1))), d);
      end else if (op == 2) begin
        busWrite(16'h0140, $urandom());
      end else if (op == 3) begin
        d = $urandom();
        d[0] = ($urandom_range(0, 3) != 0);
        busWrite(16'h0144, d);
      end else if (op <= 5) begin
        busRead(rd_addrs[$urandom_range(0, 15)]);
      end else if (op == 6) begin
        busWrite(($urandom_range(0, 1) == 1) ? 16'h014C : 16'h0150, $urandom());
      end else if (op == 7) begin
        busWrite(rd_addrs[$urandom_range(10, 15)], $urandom());
      end else begin
        idle(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
